// File: rtl/imem_readback.sv
`default_nettype none
// ============================================================================
// imem_readback : walks a range of instruction memory through its synchronous
//                 read port, streams it on valid/ready and keeps a checksum.
// Rev 1.0
// ============================================================================
module imem_readback #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              hold_cpu,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] C_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] C_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     cnt_q;
  logic [ADDR_W:0]     issued_q;
  logic                rd_en_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                rd_last_q;
  logic                cap_q;
  logic [ADDR_W-1:0]   cap_addr_q;
  logic                cap_last_q;
  logic [DATA_W-1:0]   fifo_data_q [2];
  logic [ADDR_W-1:0]   fifo_addr_q [2];
  logic [1:0]          fifo_last_q;
  logic                wptr_q, rptr_q;
  logic [1:0]          fcnt_q;
  logic [DATA_W-1:0]   sum_q;

  logic [ADDR_W:0]     cnt_clamp;
  logic                accept, go, push, pop, issue;
  logic [2:0]          occ;

  assign cnt_clamp = count[ADDR_W] ? C_FULL : count;
  assign accept    = (state_q == S_IDLE) && start;
  assign go        = accept && (count != '0);
  assign push      = cap_q;
  assign pop       = out_valid && out_ready;

  // Everything already committed (buffered, on the read bus, in the RAM) must
  // fit in the FIFO even if the consumer stalls indefinitely from now on.
  assign occ   = {1'b0, fcnt_q} + {2'b00, rd_en_q} + {2'b00, cap_q} - {2'b00, pop};
  assign issue = (state_q == S_RUN) && (issued_q != cnt_q) && (occ < 3'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (count == '0) ? S_FIN : S_RUN;
      S_RUN:  if (pop && out_last) state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q         <= '0;
      cnt_q          <= '0;
      issued_q       <= '0;
      rd_en_q        <= 1'b0;
      rd_addr_q      <= '0;
      rd_last_q      <= 1'b0;
      cap_q          <= 1'b0;
      cap_addr_q     <= '0;
      cap_last_q     <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_addr_q[0] <= '0;
      fifo_addr_q[1] <= '0;
      fifo_last_q    <= '0;
      wptr_q         <= 1'b0;
      rptr_q         <= 1'b0;
      fcnt_q         <= '0;
      sum_q          <= '0;
    end else begin
      rd_en_q <= 1'b0;
      if (accept) begin
        base_q <= base_addr;
        cnt_q  <= cnt_clamp;
      end
      // The first read goes out straight from the start edge.
      if (go) begin
        rd_en_q   <= 1'b1;
        rd_addr_q <= base_addr;
        rd_last_q <= (cnt_clamp == C_ONE);
        issued_q  <= C_ONE;
      end else if (issue) begin
        rd_en_q   <= 1'b1;
        rd_addr_q <= base_q + issued_q[ADDR_W-1:0];
        rd_last_q <= ((issued_q + C_ONE) == cnt_q);
        issued_q  <= issued_q + C_ONE;
      end

      cap_q      <= rd_en_q;
      cap_addr_q <= rd_addr_q;
      cap_last_q <= rd_last_q;

      if (push) begin
        fifo_data_q[wptr_q] <= rd_data;
        fifo_addr_q[wptr_q] <= cap_addr_q;
        fifo_last_q[wptr_q] <= cap_last_q;
        wptr_q              <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      fcnt_q <= fcnt_q + {1'b0, push} - {1'b0, pop};

      if (accept)   sum_q <= '0;
      else if (pop) sum_q <= sum_q + out_data;
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign out_valid = (fcnt_q != 2'd0);
  assign out_data  = fifo_data_q[rptr_q];
  assign out_addr  = fifo_addr_q[rptr_q];
  assign out_last  = fifo_last_q[rptr_q] && out_valid;
  assign busy      = (state_q == S_RUN) || (state_q == S_FIN);
  assign hold_cpu  = busy;
  assign done      = (state_q == S_FIN);
  assign checksum  = sum_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_readback.sv
`default_nettype none
// ============================================================================
// tb_imem_readback : directed bench for imem_readback with a behavioural
//                    synchronous-read instruction memory.
// Rev 1.0
// ============================================================================
module tb_imem_readback;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] count;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [9:0]  out_addr;
  logic        out_last;
  logic        busy;
  logic        hold_cpu;
  logic        done;
  logic [31:0] checksum;

  imem_readback #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .busy      (busy),
    .hold_cpu  (hold_cpu),
    .done      (done),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-run observation, cleared whenever clr_seq changes
  int          clr_seq = 0, seen_seq = 0, start_cyc = 0;
  int          n_rd, n_acc, n_done, n_busy, first_rd, first_val, done_rel, max_out;
  logic [31:0] acc_d [$];
  logic [9:0]  acc_a [$];
  logic        acc_l [$];
  logic [9:0]  rd_q  [$];
  logic        stalled = 1'b0;
  logic [31:0] prev_d;
  logic [9:0]  prev_a;
  logic        prev_l;
  bit          tog = 1'b0;

  always @(negedge clk) begin
    if (seen_seq != clr_seq) begin
      seen_seq = clr_seq;
      n_rd = 0; n_acc = 0; n_done = 0; n_busy = 0;
      first_rd = -1; first_val = -1; done_rel = -1; max_out = 0;
      acc_d.delete(); acc_a.delete(); acc_l.delete(); rd_q.delete();
    end
    if (rst) begin
      if (rd_en) begin
        rd_q.push_back(rd_addr);
        n_rd++;
        if (first_rd < 0) first_rd = cyc - start_cyc;
      end
      if (out_valid && first_val < 0) first_val = cyc - start_cyc;
      if (done) begin n_done++; done_rel = cyc - start_cyc; end
      if (busy) n_busy++;
      if (n_rd - n_acc > max_out) max_out = n_rd - n_acc;
      if (stalled) begin
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        check("stall_data", {22'd0, out_last, out_addr, out_data}, {22'd0, prev_l, prev_a, prev_d});
      end
      if (out_valid && out_ready) begin
        acc_d.push_back(out_data);
        acc_a.push_back(out_addr);
        acc_l.push_back(out_last);
        n_acc++;
      end
      stalled = out_valid && !out_ready;
      prev_d = out_data; prev_a = out_addr; prev_l = out_last;
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = tog ? ~out_ready : 1'b1;
    end
  end

  task automatic do_run(input logic [9:0] b, input logic [10:0] c, input bit mid);
    bit got;
    clr_seq++;
    @(posedge clk); #1;
    base_addr = b; count = c; start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 10'h155; count = 11'd7;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else if (mid && (cyc - start_cyc) == 2) begin
        start = 1'b1; base_addr = 10'd0; count = 11'd5;
      end else start = 1'b0;
    end
    start = 1'b0;
    if (!got) check("run_timeout", 64'd0, 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag, input int n, input logic [31:0] ed [4],
                              input logic [9:0] ea [4]);
    check({tag, "_nwords"}, acc_d.size(), n);
    for (int i = 0; i < n && i < acc_d.size(); i++) begin
      check({tag, "_data"}, acc_d[i], ed[i]);
      check({tag, "_addr"}, acc_a[i], ea[i]);
      check({tag, "_last"}, acc_l[i], (i == n - 1));
    end
  endtask

  logic [31:0] img_d [4];
  logic [9:0]  img_a [4];
  bit          got2;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[0] = 32'h11111111; mem[1] = 32'h22222222;
    mem[2] = 32'h33333333; mem[3] = 32'h44444444;
    mem[1022] = 32'hA0000001; mem[1023] = 32'hA0000002;
    mem[8] = 32'hFFFFFFFF; mem[9] = 32'h00000002;
    rst = 1'b0; start = 1'b0; base_addr = '0; count = '0;

    // Reset state
    #3;
    check("rst_rd_en", rd_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy_hold_done", {busy, hold_cpu, done}, 0);
    check("rst_checksum", checksum, 0);
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk); #1;

    // T1: straight image, consumer always ready
    img_d = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    img_a = '{10'd0, 10'd1, 10'd2, 10'd3};
    do_run(10'd0, 11'd4, 1'b0);
    check_stream("t1", 4, img_d, img_a);
    check("t1_checksum", checksum, 32'hAAAAAAAA);
    check("t1_done_cycles", n_done, 1);
    check("t1_rd_latency", first_rd, 1);
    check("t1_valid_latency", first_val, 3);
    check("t1_reads", n_rd, 4);
    check("t1_idle_after", {busy, done}, 0);

    // T2: consumer toggling ready
    tog = 1'b1;
    do_run(10'd0, 11'd4, 1'b0);
    tog = 1'b0;
    check_stream("t2", 4, img_d, img_a);
    check("t2_checksum", checksum, 32'hAAAAAAAA);
    check("t2_outstanding_le2", (max_out <= 2), 1);

    // T3: address wrap
    img_d = '{32'hA0000001, 32'hA0000002, 32'h11111111, 32'h22222222};
    img_a = '{10'd1022, 10'd1023, 10'd0, 10'd1};
    do_run(10'd1022, 11'd4, 1'b0);
    check_stream("t3", 4, img_d, img_a);
    check("t3_rd_nreads", rd_q.size(), 4);
    for (int i = 0; i < 4 && i < rd_q.size(); i++) check("t3_rd_addr", rd_q[i], img_a[i]);
    check("t3_checksum", checksum, 32'h73333336);

    // T4: empty run
    do_run(10'd5, 11'd0, 1'b0);
    check("t4_reads", n_rd, 0);
    check("t4_done_rel", done_rel, 1);
    check("t4_done_cycles", n_done, 1);
    check("t4_busy_cycles", n_busy, 1);
    check("t4_checksum", checksum, 0);

    // T5: reset after two accepted words
    clr_seq++;
    @(posedge clk); #1;
    base_addr = 10'd0; count = 11'd4; start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1; start = 1'b0;
    got2 = 1'b0;
    for (int i = 0; i < 50 && !got2; i++) begin
      @(negedge clk); #1;
      if (n_acc == 2) got2 = 1'b1;
    end
    if (!got2) check("t5_timeout", 64'd0, 64'd1);
    #1 rst = 1'b0;
    #1;
    check("t5_rst_rd_en", rd_en, 0);
    check("t5_rst_valid_last", {out_valid, out_last}, 0);
    check("t5_rst_busy_hold_done", {busy, hold_cpu, done}, 0);
    check("t5_rst_checksum", checksum, 0);
    check("t5_rst_rd_addr", rd_addr, 0);
    @(posedge clk); #1; rst = 1'b1;
    clr_seq++;
    repeat (4) @(posedge clk); #1;
    check("t5_no_reads_after_rst", n_rd, 0);
    img_d = '{32'h11111111, 32'h22222222, 32'h0, 32'h0};
    img_a = '{10'd0, 10'd1, 10'd0, 10'd0};
    do_run(10'd0, 11'd2, 1'b0);
    check_stream("t5", 2, img_d, img_a);
    check("t5_checksum", checksum, 32'h33333333);

    // T6: overflowing sum, second start mid-run ignored
    img_d = '{32'hFFFFFFFF, 32'h00000002, 32'h0, 32'h0};
    img_a = '{10'd8, 10'd9, 10'd0, 10'd0};
    do_run(10'd8, 11'd2, 1'b1);
    check_stream("t6", 2, img_d, img_a);
    check("t6_checksum", checksum, 32'h00000001);
    check("t6_reads", n_rd, 2);
    repeat (6) @(posedge clk); #1;
    check("t6_stays_idle", {busy, rd_en, out_valid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
